// File: rtl/mandel_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot pixel pipeline
// (pixel_to_complex, pixel_distributor, mandelbrot_iterator).
package mandel_pkg;

  localparam int FRAC        = 60;
  localparam int WORD_LENGTH = 64;
  localparam int ITER_W      = 16;
  localparam int TAG_W       = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 4.0 at the widened escape-sum width, so |z|^2 never overflows the compare
  localparam logic signed [2*WORD_LENGTH:0] ESCAPE_SQ =
    (2*WORD_LENGTH+1)'(4) << FRAC;

endpackage

// File: rtl/fxp_mul.sv
// Signed WL x WL fixed-point multiply, full 2*WL product, then arithmetic
// right shift by SHIFT.
module fxp_mul #(
  parameter int WL    = 64,
  parameter int SHIFT = 60
) (
  input  logic signed [WL-1:0]   a_i,
  input  logic signed [WL-1:0]   b_i,
  output logic signed [2*WL-1:0] p_o
);

  logic signed [2*WL-1:0] a_ext;
  logic signed [2*WL-1:0] b_ext;
  logic signed [2*WL-1:0] prod;

  assign a_ext = {{WL{a_i[WL-1]}}, a_i};
  assign b_ext = {{WL{b_i[WL-1]}}, b_i};
  assign prod  = a_ext * b_ext;
  assign p_o   = prod >>> SHIFT;

endmodule

// File: rtl/mandelbrot_iterator.sv
// Escape-time engine: one z <- z^2 + c iteration per clock, returns the
// iteration count at escape (|z|^2 > 4) or at the latched max_iter.
//   state   | meaning
//   ST_IDLE | ready for a new coordinate
//   ST_ITER | iterating, one step per cycle
//   ST_DONE | result held until out_ready
module mandelbrot_iterator
  import mandel_pkg::*;
(
  input  logic                          sysclk_i,
  input  logic                          rst_n_i,
  input  logic [ITER_W-1:0]             max_iter_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic signed [WORD_LENGTH-1:0] re_c_i,
  input  logic signed [WORD_LENGTH-1:0] im_c_i,
  input  logic [TAG_W-1:0]              x_in_i,
  input  logic [TAG_W-1:0]              y_in_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ITER_W-1:0]             iter_count_o,
  output logic                          escaped_o,
  output logic [TAG_W-1:0]              x_out_o,
  output logic [TAG_W-1:0]              y_out_o
);

  localparam int PW = 2*WORD_LENGTH;

  state_e state_q, state_d;

  logic signed [WORD_LENGTH-1:0] zr_q, zi_q, re_q, im_q;
  logic signed [WORD_LENGTH-1:0] zr_d, zi_d;
  logic [ITER_W-1:0]             iter_q, iter_d, max_q;
  logic [TAG_W-1:0]              x_q, y_q;
  logic                          esc_q, out_valid_q;

  logic signed [PW-1:0] sr, si, m, diff;
  logic signed [PW:0]   mag;
  logic                 escape, at_max;
  logic                 load, step, finish;
  logic                 unused_hi;

  fxp_mul #(.WL(WORD_LENGTH), .SHIFT(FRAC))   u_mul_sr (.a_i(zr_q), .b_i(zr_q), .p_o(sr));
  fxp_mul #(.WL(WORD_LENGTH), .SHIFT(FRAC))   u_mul_si (.a_i(zi_q), .b_i(zi_q), .p_o(si));
  // Shifting one bit less than FRAC folds the factor 2 of 2*zr*zi into m
  fxp_mul #(.WL(WORD_LENGTH), .SHIFT(FRAC-1)) u_mul_m  (.a_i(zr_q), .b_i(zi_q), .p_o(m));

  assign diff   = sr - si;
  assign mag    = {sr[PW-1], sr} + {si[PW-1], si};
  assign escape = mag > ESCAPE_SQ;
  assign at_max = (iter_q == max_q);

  // Wrap in the truncation is harmless: escape is detected before it matters
  assign zr_d      = diff[WORD_LENGTH-1:0] + re_q;
  assign zi_d      = m[WORD_LENGTH-1:0] + im_q;
  assign iter_d    = iter_q + ITER_W'(1);
  assign unused_hi = ^{diff[PW-1:WORD_LENGTH], m[PW-1:WORD_LENGTH]};

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i)       state_d = ST_ITER;
      ST_ITER: if (escape || at_max) state_d = ST_DONE;
      ST_DONE: if (out_ready_i)      state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == ST_IDLE);
    load       = (state_q == ST_IDLE) && in_valid_i;
    finish     = (state_q == ST_ITER) && (escape || at_max);
    step       = (state_q == ST_ITER) && !(escape || at_max);
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      zr_q        <= '0;
      zi_q        <= '0;
      re_q        <= '0;
      im_q        <= '0;
      iter_q      <= '0;
      max_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      esc_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (load) begin
        zr_q   <= '0;
        zi_q   <= '0;
        re_q   <= re_c_i;
        im_q   <= im_c_i;
        iter_q <= '0;
        max_q  <= max_iter_i;
        x_q    <= x_in_i;
        y_q    <= y_in_i;
      end
      if (step) begin
        zr_q   <= zr_d;
        zi_q   <= zi_d;
        iter_q <= iter_d;
      end
      if (finish) begin
        esc_q       <= escape;
        out_valid_q <= 1'b1;
      end
      if ((state_q == ST_DONE) && out_ready_i) out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign iter_count_o = iter_q;
  assign escaped_o    = esc_q;
  assign x_out_o      = x_q;
  assign y_out_o      = y_q;

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed self-checking bench for mandelbrot_iterator; expected counts and
// latencies are hand-derived from the escape-time recurrence.
module tb_mandelbrot_iterator;
  import mandel_pkg::*;

  localparam logic signed [63:0] FX_ZERO  = 64'sh0000_0000_0000_0000;
  localparam logic signed [63:0] FX_TWO   = 64'sh2000_0000_0000_0000;
  localparam logic signed [63:0] FX_THREE = 64'sh3000_0000_0000_0000;
  localparam logic signed [63:0] FX_NTWO  = 64'shE000_0000_0000_0000;
  localparam int TIMEOUT = 3000;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [ITER_W-1:0]             max_iter;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [WORD_LENGTH-1:0] re_c, im_c;
  logic [TAG_W-1:0]              x_in, y_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [ITER_W-1:0]             iter_count;
  logic                          escaped;
  logic [TAG_W-1:0]              x_out, y_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mandelbrot_iterator dut (
    .sysclk_i    (clk),
    .rst_n_i     (rst_n),
    .max_iter_i  (max_iter),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .re_c_i      (re_c),
    .im_c_i      (im_c),
    .x_in_i      (x_in),
    .y_in_i      (y_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .iter_count_o(iter_count),
    .escaped_o   (escaped),
    .x_out_o     (x_out),
    .y_out_o     (y_out)
  );

  // Presents one job for a single accept edge; returns #1 after that edge
  task automatic launch(input logic signed [63:0] re, input logic signed [63:0] im,
                        input logic [15:0] mx, input logic [10:0] x, input logic [10:0] y);
    @(negedge clk);
    re_c = re; im_c = im; max_iter = mx; x_in = x; y_in = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // k counts cycles from the accept cycle to the first cycle with out_valid
  task automatic wait_result(output int k, output bit to);
    bit done;
    k = 1; to = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else if (k >= TIMEOUT) begin to = 1'b1; done = 1'b1; end
      else begin @(posedge clk); k++; end
    end
  endtask

  task automatic release_result;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    n_checks++;
    if (out_valid !== 1'b0 || iter_count !== 16'd0 || escaped !== 1'b0 ||
        x_out !== 11'd0 || y_out !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b iter=%0d esc=%b x=%0d y=%0d, expected all 0",
               out_valid, iter_count, escaped, x_out, y_out);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic run_and_check(input string name, input logic signed [63:0] re,
                               input logic [15:0] mx, input logic [15:0] exp_n,
                               input logic exp_esc);
    int k; bit to;
    launch(re, FX_ZERO, mx, 11'd10, 11'd20);
    wait_result(k, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL %s_timeout: no out_valid within %0d cycles", name, TIMEOUT);
    end else begin
      n_checks++;
      if (iter_count !== exp_n || escaped !== exp_esc) begin
        n_fail++;
        $display("FAIL %s_result: got iter=%0d esc=%b, expected iter=%0d esc=%b",
                 name, iter_count, escaped, exp_n, exp_esc);
      end
      n_checks++;
      if (k !== int'(exp_n) + 2) begin
        n_fail++;
        $display("FAIL %s_latency: out_valid in cycle T+%0d, expected T+%0d", name, k, exp_n + 2);
      end
    end
    release_result();
  endtask

  task automatic test_origin;          run_and_check("origin",   FX_ZERO,  16'd100, 16'd100, 1'b0); endtask
  task automatic test_escape_boundary; run_and_check("two",      FX_TWO,   16'd50,  16'd2,   1'b1); endtask
  task automatic test_neg_two;         run_and_check("neg_two",  FX_NTWO,  16'd64,  16'd64,  1'b0); endtask
  task automatic test_max_iter_zero;   run_and_check("max_zero", FX_THREE, 16'd0,   16'd0,   1'b0); endtask

  task automatic test_tag_ready;
    int k; bit done;
    launch(FX_THREE, FX_ZERO, 16'd20, 11'd639, 11'd479);
    re_c = FX_ZERO; max_iter = 16'd0;   // must not affect the job in flight
    k = 1; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL tag_in_ready_busy: cycle T+%0d in_ready=%b, expected 0", k, in_ready);
      end
      if (out_valid || k >= TIMEOUT) done = 1'b1;
      else begin @(posedge clk); k++; end
    end
    n_checks++;
    if (out_valid !== 1'b1 || k !== 3) begin
      n_fail++;
      $display("FAIL tag_latency: out_valid=%b in cycle T+%0d, expected 1 in T+3", out_valid, k);
    end
    n_checks++;
    if (iter_count !== 16'd1 || escaped !== 1'b1 || x_out !== 11'd639 || y_out !== 11'd479) begin
      n_fail++;
      $display("FAIL tag_result: got iter=%0d esc=%b x=%0d y=%0d, expected 1 1 639 479",
               iter_count, escaped, x_out, y_out);
    end
    release_result();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tag_after_handshake: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int k; bit to;
    launch(FX_TWO, FX_ZERO, 16'd50, 11'd5, 11'd7);
    wait_result(k, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL bp_timeout: no out_valid within %0d cycles", TIMEOUT);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || iter_count !== 16'd2 || escaped !== 1'b1 ||
          x_out !== 11'd5 || y_out !== 11'd7 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b iter=%0d esc=%b x=%0d y=%0d rdy=%b, expected 1 2 1 5 7 0",
                 i, out_valid, iter_count, escaped, x_out, y_out, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int outs[$];
    int bad_iter;
    bad_iter = 0;
    @(negedge clk);
    re_c = FX_THREE; im_c = FX_ZERO; max_iter = 16'd10; x_in = 11'd1; y_in = 11'd2;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (in_ready) acc.push_back(i);
      if (out_valid) begin
        outs.push_back(i);
        if (iter_count !== 16'd1) bad_iter++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (acc.size() != 4 || outs.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_counts: accepts=%0d results=%0d, expected 4 4", acc.size(), outs.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (acc[j] != 4*j || outs[j] != 4*j + 3) begin
          n_fail++;
          $display("FAIL b2b_timing job %0d: accept=%0d result=%0d, expected %0d %0d",
                   j, acc[j], outs[j], 4*j, 4*j + 3);
        end
      end
    end
    n_checks++;
    if (bad_iter != 0) begin
      n_fail++;
      $display("FAIL b2b_iter: %0d results with iter_count != 1", bad_iter);
    end
  endtask

  task automatic test_reset_mid_job;
    int k; bit to; int seen;
    launch(FX_ZERO, FX_ZERO, 16'd100, 11'd3, 11'd4);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || iter_count !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_iter_async: valid=%b iter=%0d rdy=%b, expected 0 0 1",
               out_valid, iter_count, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_iter_no_result: out_valid seen %0d cycles, expected 0", seen);
    end
    launch(FX_THREE, FX_ZERO, 16'd10, 11'd9, 11'd8);
    wait_result(k, to);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || x_out !== 11'd0 || y_out !== 11'd0 || escaped !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_done_async: valid=%b x=%0d y=%0d esc=%b, expected 0 0 0 0",
               out_valid, x_out, y_out, escaped);
    end
    @(negedge clk) rst_n = 1'b1;
    launch(FX_THREE, FX_ZERO, 16'd10, 11'd11, 11'd12);
    wait_result(k, to);
    n_checks++;
    if (to || iter_count !== 16'd1 || escaped !== 1'b1 || x_out !== 11'd11 || k !== 3) begin
      n_fail++;
      $display("FAIL rst_next_job: timeout=%b iter=%0d esc=%b x=%0d cycle=T+%0d, expected 0 1 1 11 T+3",
               to, iter_count, escaped, x_out, k);
    end
    release_result();
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    re_c = '0; im_c = '0; max_iter = '0; x_in = '0; y_in = '0;
    test_reset();
    test_origin();
    test_escape_boundary();
    test_neg_two();
    test_max_iter_zero();
    test_tag_ready();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
